// File: rtl/ras_shadow_stack_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ras_shadow_stack_ctrl
// Brief   : CFI checker that sits in front of ras_shadow_stack. Calls push their
//           return address and returns pop-and-compare. A mismatch raises a sticky fault.
//           Optional SS_OVERFLOW_TRAP_EN: a push to a full stack traps instead of being dropped.
// Rev     : 1.0
// ============================================================================
module ras_shadow_stack_ctrl #(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_is_call,
    input  logic              i_is_ret,
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_compressed,
    input  logic [DATA_W-1:0] i_target,
    output logic              o_ss_push,
    output logic [DATA_W-1:0] o_ss_data,
    output logic              o_ss_pop,
    input  logic [DATA_W-1:0] i_ss_top,
    input  logic              i_ss_full,
    input  logic              i_ss_empty,
    output logic              o_fault,
    output logic [1:0]        o_fault_cause,
    output logic [DATA_W-1:0] o_fault_addr,
    input  logic              i_clear
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CHECK = 2'd1,
        S_PUSH  = 2'd2,
        S_FAULT = 2'd3
    } state_t;

    localparam logic [1:0] c_CAUSE_NONE      = 2'b00;
    localparam logic [1:0] c_CAUSE_MISMATCH  = 2'b01;
    localparam logic [1:0] c_CAUSE_UNDERFLOW = 2'b10;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   ret_addr_q, ret_addr_d;
    logic [DATA_W-1:0]   target_q, target_d;
    logic                call_q, call_d;
    logic                ss_push_q, ss_push_d;
    logic                ss_pop_q, ss_pop_d;
    logic [DATA_W-1:0]   ss_data_q, ss_data_d;
    logic                fault_q, fault_d;
    logic [1:0]          cause_q, cause_d;
    logic [DATA_W-1:0]   fault_addr_q, fault_addr_d;

`ifdef SS_OVERFLOW_TRAP_EN
    localparam logic [1:0] c_CAUSE_OVERFLOW = 2'b11;
    // A pop issued last cycle has not reached the stack's full flag yet.
    logic w_full_eff;
    assign w_full_eff = i_ss_full & ~ss_pop_q;
`else
    logic w_unused_full;
    assign w_unused_full = i_ss_full;
`endif

    always_comb begin
        state_d      = state_q;
        ret_addr_d   = ret_addr_q;
        target_d     = target_q;
        call_d       = call_q;
        ss_push_d    = 1'b0;
        ss_pop_d     = 1'b0;
        ss_data_d    = ss_data_q;
        fault_d      = fault_q;
        cause_d      = cause_q;
        fault_addr_d = fault_addr_q;

        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    ret_addr_d = i_pc + DATA_W'(i_compressed ? 2 : 4);
                    target_d   = i_target;
                    call_d     = i_is_call;
                    if (i_is_ret) begin
                        state_d = S_CHECK;
                    end else if (i_is_call) begin
                        state_d = S_PUSH;
                    end
                end
            end
            S_PUSH: begin
`ifdef SS_OVERFLOW_TRAP_EN
                if (w_full_eff) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    cause_d      = c_CAUSE_OVERFLOW;
                    fault_addr_d = '0;
                end else
`endif
                begin
                    ss_push_d = 1'b1;
                    ss_data_d = ret_addr_q;
                    state_d   = S_IDLE;
                end
            end
            S_CHECK: begin
                if (i_ss_empty) begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    cause_d      = c_CAUSE_UNDERFLOW;
                    fault_addr_d = target_q;
                end else if (i_ss_top == target_q) begin
                    ss_pop_d = 1'b1;
                    state_d  = call_q ? S_PUSH : S_IDLE;
                end else begin
                    state_d      = S_FAULT;
                    fault_d      = 1'b1;
                    cause_d      = c_CAUSE_MISMATCH;
                    fault_addr_d = target_q;
                end
            end
            S_FAULT: begin
                if (i_clear) begin
                    state_d      = S_IDLE;
                    fault_d      = 1'b0;
                    cause_d      = c_CAUSE_NONE;
                    fault_addr_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            ret_addr_q   <= '0;
            target_q     <= '0;
            call_q       <= 1'b0;
            ss_push_q    <= 1'b0;
            ss_pop_q     <= 1'b0;
            ss_data_q    <= '0;
            fault_q      <= 1'b0;
            cause_q      <= c_CAUSE_NONE;
            fault_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            ret_addr_q   <= ret_addr_d;
            target_q     <= target_d;
            call_q       <= call_d;
            ss_push_q    <= ss_push_d;
            ss_pop_q     <= ss_pop_d;
            ss_data_q    <= ss_data_d;
            fault_q      <= fault_d;
            cause_q      <= cause_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign o_ready       = (state_q == S_IDLE);
    assign o_ss_push     = ss_push_q;
    assign o_ss_pop      = ss_pop_q;
    assign o_ss_data     = ss_data_q;
    assign o_fault       = fault_q;
    assign o_fault_cause = cause_q;
    assign o_fault_addr  = fault_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ras_shadow_stack_ctrl.sv
`default_nettype none
// Bench for ras_shadow_stack_ctrl: a behavioural shadow stack drives the DUT,
// and a reference model of return addresses predicts pushes, pops and faults.
module tb_ras_shadow_stack_ctrl;
    localparam int DW    = 64;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          i_valid = 1'b0;
    logic          i_is_call = 1'b0;
    logic          i_is_ret = 1'b0;
    logic [DW-1:0] i_pc = '0;
    logic          i_compressed = 1'b0;
    logic [DW-1:0] i_target = '0;
    logic          i_clear = 1'b0;
    logic          o_ready, o_ss_push, o_ss_pop, o_fault;
    logic [DW-1:0] o_ss_data, o_fault_addr, ss_top;
    logic [1:0]    o_fault_cause;
    logic          ss_full, ss_empty;

    ras_shadow_stack_ctrl #(.DATA_W(DW)) dut (
        .clk(clk), .rstn(rstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_is_call(i_is_call), .i_is_ret(i_is_ret), .i_pc(i_pc),
        .i_compressed(i_compressed), .i_target(i_target),
        .o_ss_push(o_ss_push), .o_ss_data(o_ss_data), .o_ss_pop(o_ss_pop),
        .i_ss_top(ss_top), .i_ss_full(ss_full), .i_ss_empty(ss_empty),
        .o_fault(o_fault), .o_fault_cause(o_fault_cause),
        .o_fault_addr(o_fault_addr), .i_clear(i_clear)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Environment: the downstream stack, driven only by the DUT's requests.
    logic [DW-1:0] stk_mem [DEPTH];
    int            stk_cnt = 0;
    logic          stk_flush = 1'b0;
    always @(posedge clk) begin
        if (stk_flush) stk_cnt <= 0;
        else if (o_ss_pop && stk_cnt > 0) stk_cnt <= stk_cnt - 1;
        else if (o_ss_push && stk_cnt < DEPTH) begin
            stk_mem[stk_cnt] <= o_ss_data;
            stk_cnt          <= stk_cnt + 1;
        end
    end
    assign ss_top   = (stk_cnt > 0) ? stk_mem[stk_cnt-1] : '0;
    assign ss_full  = (stk_cnt == DEPTH);
    assign ss_empty = (stk_cnt == 0);

    // Reference model
    logic [DW-1:0] mstk[$];
    logic [DW-1:0] exp_push[$];
    int            exp_pops = 0;
    logic          m_fault = 1'b0;
    logic [1:0]    m_cause = 2'b00;
    logic [DW-1:0] m_addr = '0;
    int            acc_cyc = 0, last_push_cyc = -1, last_pop_cyc = -1;
    logic [DW-1:0] last_push_data = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            check("push_pop_exclusive", {63'd0, o_ss_push & o_ss_pop}, 64'd0);
            if (o_ss_push) begin
                last_push_cyc  = cyc;
                last_push_data = o_ss_data;
                check("push_expected", {63'd0, exp_push.size() > 0}, 64'd1);
                if (exp_push.size() > 0) check("push_data", o_ss_data, exp_push.pop_front());
            end
            if (o_ss_pop) begin
                last_pop_cyc = cyc;
                check("pop_expected", {63'd0, exp_pops > 0}, 64'd1);
                if (exp_pops > 0) exp_pops--;
            end
        end
    end

    task automatic model_push(input logic [DW-1:0] ra);
        if (mstk.size() == DEPTH) begin
`ifdef SS_OVERFLOW_TRAP_EN
            m_fault = 1'b1; m_cause = 2'b11; m_addr = '0;
`else
            exp_push.push_back(ra);
`endif
        end else begin
            exp_push.push_back(ra);
            mstk.push_back(ra);
        end
    endtask

    task automatic run_op(input logic call, input logic ret, input logic [DW-1:0] pc,
                          input logic comp, input logic [DW-1:0] tgt);
        logic [DW-1:0] ra;
        bit ok;
        ra = pc + (comp ? 64'd2 : 64'd4);
        if (ret) begin
            if (mstk.size() == 0) begin
                m_fault = 1'b1; m_cause = 2'b10; m_addr = tgt;
            end else if (mstk[$] == tgt) begin
                exp_pops++;
                void'(mstk.pop_back());
                if (call) model_push(ra);
            end else begin
                m_fault = 1'b1; m_cause = 2'b01; m_addr = tgt;
            end
        end else if (call) begin
            model_push(ra);
        end
        ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            ok = o_ready;
        end
        check("ready_before_op", {63'd0, ok}, 64'd1);
        i_valid = 1'b1; i_is_call = call; i_is_ret = ret;
        i_pc = pc; i_compressed = comp; i_target = tgt;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        i_valid = 1'b0; i_is_call = 1'b0; i_is_ret = 1'b0;
        repeat (4) @(negedge clk);
        check("pending_push", 64'(exp_push.size()), 64'd0);
        check("pending_pop", 64'(exp_pops), 64'd0);
        check("fault", {63'd0, o_fault}, {63'd0, m_fault});
        check("fault_cause", {62'd0, o_fault_cause}, {62'd0, m_cause});
        check("fault_addr", o_fault_addr, m_addr);
        check("ready_after_op", {63'd0, o_ready}, {63'd0, ~m_fault});
        check("stack_depth", 64'(stk_cnt), 64'(mstk.size()));
    endtask

    task automatic clear_fault();
        @(negedge clk); i_clear = 1'b1;
        @(posedge clk); #1; i_clear = 1'b0;
        m_fault = 1'b0; m_cause = 2'b00; m_addr = '0;
        @(negedge clk);
        check("clear_fault", {63'd0, o_fault}, 64'd0);
        check("clear_cause", {62'd0, o_fault_cause}, 64'd0);
        check("clear_addr", o_fault_addr, 64'd0);
        check("clear_ready", {63'd0, o_ready}, 64'd1);
    endtask

    task automatic flush_stack();
        @(negedge clk); stk_flush = 1'b1;
        @(negedge clk); stk_flush = 1'b0;
        mstk.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", {63'd0, o_ready}, 64'd1);
        check("rst_push", {63'd0, o_ss_push}, 64'd0);
        check("rst_pop", {63'd0, o_ss_pop}, 64'd0);
        check("rst_data", o_ss_data, 64'd0);
        check("rst_fault", {63'd0, o_fault}, 64'd0);
        rstn = 1'b1;

        // 1: plain call/return pair
        run_op(1'b1, 1'b0, 64'h1000, 1'b0, 64'h0);
        check("t1_push_latency", 64'(last_push_cyc - acc_cyc), 64'd1);
        check("t1_push_data", last_push_data, 64'h1004);
        run_op(1'b0, 1'b1, 64'h1100, 1'b0, 64'h1004);
        check("t1_pop_latency", 64'(last_pop_cyc - acc_cyc), 64'd1);
        check("t1_stack_empty", 64'(stk_cnt), 64'd0);
        run_op(1'b0, 1'b0, 64'h1200, 1'b0, 64'h1234);

        // 2: compressed call, return to wrong address
        run_op(1'b1, 1'b0, 64'h2000, 1'b1, 64'h0);
        check("t2_push_data", last_push_data, 64'h2002);
        run_op(1'b0, 1'b1, 64'h2100, 1'b0, 64'h2004);
        check("t2_cause", {62'd0, o_fault_cause}, 64'd1);
        check("t2_addr", o_fault_addr, 64'h2004);
        clear_fault();

        // 3: underflow holds o_ready low until cleared
        flush_stack();
        run_op(1'b0, 1'b1, 64'h3100, 1'b0, 64'h3333);
        check("t3_cause", {62'd0, o_fault_cause}, 64'd2);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t3_ready_held", {63'd0, o_ready}, 64'd0);
        end
        clear_fault();

        // 4: coroutine swap pops then pushes on the next cycle
        flush_stack();
        run_op(1'b1, 1'b0, 64'h2FFC, 1'b0, 64'h0);
        run_op(1'b1, 1'b1, 64'h4000, 1'b0, 64'h3000);
        check("t4_pop_latency", 64'(last_pop_cyc - acc_cyc), 64'd1);
        check("t4_push_latency", 64'(last_push_cyc - acc_cyc), 64'd2);
        check("t4_push_data", last_push_data, 64'h4004);

        // 5: DEPTH+1 nested calls, then unwind
        flush_stack();
        for (int i = 0; i <= DEPTH; i++) run_op(1'b1, 1'b0, 64'h5000 + 64'(i) * 64'h100, 1'b0, 64'h0);
`ifdef SS_OVERFLOW_TRAP_EN
        check("t5_overflow_cause", {62'd0, o_fault_cause}, 64'd3);
        check("t5_overflow_addr", o_fault_addr, 64'd0);
        clear_fault();
`else
        check("t5_no_fault", {63'd0, o_fault}, 64'd0);
`endif
        for (int i = DEPTH - 1; i >= 0; i--) run_op(1'b0, 1'b1, 64'h6000, 1'b0, 64'h5004 + 64'(i) * 64'h100);
        run_op(1'b0, 1'b1, 64'h6000, 1'b0, 64'h5004 + 64'(DEPTH) * 64'h100);
        check("t5_underflow", {62'd0, o_fault_cause}, 64'd2);
        clear_fault();

        // 6: asynchronous reset during CHECK and with a fault pending
        flush_stack();
        run_op(1'b1, 1'b0, 64'h6000, 1'b0, 64'h0);
        i_valid = 1'b1; i_is_ret = 1'b1; i_pc = 64'h6100; i_target = 64'h6004;
        @(posedge clk); #1;
        i_valid = 1'b0; i_is_ret = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("t6_rst_push", {63'd0, o_ss_push}, 64'd0);
        check("t6_rst_pop", {63'd0, o_ss_pop}, 64'd0);
        check("t6_rst_data", o_ss_data, 64'd0);
        check("t6_rst_ready", {63'd0, o_ready}, 64'd1);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        check("t6_op_discarded", 64'(stk_cnt), 64'd1);
        run_op(1'b0, 1'b1, 64'h7000, 1'b0, 64'h9999);
        check("t6_fault_set", {63'd0, o_fault}, 64'd1);
        #3 rstn = 1'b0;
        #1;
        m_fault = 1'b0; m_cause = 2'b00; m_addr = '0;
        check("t6_rst_fault", {63'd0, o_fault}, 64'd0);
        check("t6_rst_cause", {62'd0, o_fault_cause}, 64'd0);
        check("t6_rst_addr", o_fault_addr, 64'd0);
        @(negedge clk); rstn = 1'b1;
        @(negedge clk);
        check("t6_ready_after", {63'd0, o_ready}, 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
